// File: rtl/taxi_eth_mac_swap.sv
// taxi_eth_mac_swap: 8-bit AXI4-Stream stage that swaps the Ethernet destination
// and source MAC addresses of every frame. Frames that end before the 12-byte
// address header is complete are dropped and counted as runts.
module taxi_eth_mac_swap #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  // upstream (MAC RX FIFO output); tkeep is not used on an 8-bit bus
  input  logic [7:0]       s_axis_tdata_i,
  input  logic             s_axis_tvalid_i,
  output logic             s_axis_tready_o,
  input  logic             s_axis_tlast_i,
  input  logic             s_axis_tuser_i,
  input  logic [7:0]       s_axis_tid_i,
  // downstream (MAC TX input)
  output logic [7:0]       m_axis_tdata_o,
  output logic             m_axis_tkeep_o,
  output logic             m_axis_tvalid_o,
  input  logic             m_axis_tready_i,
  output logic             m_axis_tlast_o,
  output logic             m_axis_tuser_o,
  output logic [7:0]       m_axis_tid_o,
  // control / status
  input  logic             cfg_enable_i,
  output logic [CNT_W-1:0] stat_frame_cnt_o,
  output logic [CNT_W-1:0] stat_runt_cnt_o
);

  typedef enum logic [1:0] {
    ST_HDR,   // collecting the 12 address bytes
    ST_EMIT,  // replaying the buffered header, possibly swapped
    ST_PASS   // forwarding the rest of the frame byte for byte
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       ecnt_q, ecnt_d;
  logic             swap_q, swap_d;
  logic             hdr_last_q, hdr_last_d;
  logic             hdr_user_q, hdr_user_d;
  logic [7:0]       id_q, id_d;
  logic             rdy_q;
  logic [7:0]       hdr_q [12];

  logic [7:0]       m_tdata_q, m_tdata_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic             m_tlast_q, m_tlast_d;
  logic             m_tuser_q, m_tuser_d;
  logic [7:0]       m_tid_q, m_tid_d;

  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] runt_cnt_q;

  logic             load_slot;
  logic             s_hs;
  logic             hdr_we;
  logic             runt_inc;
  logic             frame_inc;
  logic [3:0]       src_idx;

  // The output register may take a new byte when empty or being drained.
  assign load_slot       = !m_tvalid_q || m_axis_tready_i;
  assign s_axis_tready_o = rdy_q && ((state_q == ST_HDR) ||
                                     ((state_q == ST_PASS) && load_slot));
  assign s_hs            = s_axis_tvalid_i && s_axis_tready_o;
  assign frame_inc       = m_tvalid_q && m_axis_tready_i && m_tlast_q;
  // Swapping rotates the 12-byte header by six positions.
  assign src_idx = !swap_q      ? ecnt_q :
                   (ecnt_q < 6) ? ecnt_q + 4'd6 : ecnt_q - 4'd6;

  // Next-state, header capture control and output register loading.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    ecnt_d     = ecnt_q;
    swap_d     = swap_q;
    hdr_last_d = hdr_last_q;
    hdr_user_d = hdr_user_q;
    id_d       = id_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    m_tid_d    = m_tid_q;
    m_tvalid_d = m_axis_tready_i ? 1'b0 : m_tvalid_q;
    hdr_we     = 1'b0;
    runt_inc   = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (s_hs) begin
          hdr_we = 1'b1;
          if (cnt_q == 4'd0) begin
            id_d   = s_axis_tid_i;
            swap_d = cfg_enable_i;
          end
          if (cnt_q == 4'd11) begin
            hdr_last_d = s_axis_tlast_i;
            hdr_user_d = s_axis_tuser_i;
            ecnt_d     = 4'd0;
            cnt_d      = 4'd0;
            state_d    = ST_EMIT;
          end else if (s_axis_tlast_i) begin
            runt_inc = 1'b1;
            cnt_d    = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      ST_EMIT: begin
        if (load_slot) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = hdr_q[src_idx];
          m_tid_d    = id_q;
          m_tlast_d  = (ecnt_q == 4'd11) && hdr_last_q;
          m_tuser_d  = (ecnt_q == 4'd11) && hdr_last_q && hdr_user_q;
          if (ecnt_q == 4'd11) begin
            cnt_d   = 4'd0;
            state_d = hdr_last_q ? ST_HDR : ST_PASS;
          end else begin
            ecnt_d = ecnt_q + 4'd1;
          end
        end
      end

      ST_PASS: begin
        if (s_hs) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = s_axis_tdata_i;
          m_tlast_d  = s_axis_tlast_i;
          m_tuser_d  = s_axis_tuser_i;
          m_tid_d    = s_axis_tid_i;
          if (s_axis_tlast_i) begin
            cnt_d   = 4'd0;
            state_d = ST_HDR;
          end
        end
      end

      default: state_d = ST_HDR;
    endcase
  end

  // Control state, output register and statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HDR;
      cnt_q       <= '0;
      ecnt_q      <= '0;
      swap_q      <= 1'b0;
      hdr_last_q  <= 1'b0;
      hdr_user_q  <= 1'b0;
      id_q        <= '0;
      rdy_q       <= 1'b0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= 1'b0;
      m_tid_q     <= '0;
      frame_cnt_q <= '0;
      runt_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ecnt_q     <= ecnt_d;
      swap_q     <= swap_d;
      hdr_last_q <= hdr_last_d;
      hdr_user_q <= hdr_user_d;
      id_q       <= id_d;
      rdy_q      <= 1'b1;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      m_tid_q    <= m_tid_d;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      if (runt_inc)  runt_cnt_q  <= runt_cnt_q + CNT_W'(1);
    end
  end

  // Header byte buffer, written in arrival order.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; each entry is written by the current frame before EMIT reads it.
    if (hdr_we) hdr_q[cnt_q] <= s_axis_tdata_i;
  end

  assign m_axis_tdata_o   = m_tdata_q;
  assign m_axis_tkeep_o   = 1'b1;
  assign m_axis_tvalid_o  = m_tvalid_q;
  assign m_axis_tlast_o   = m_tlast_q;
  assign m_axis_tuser_o   = m_tuser_q;
  assign m_axis_tid_o     = m_tid_q;
  assign stat_frame_cnt_o = frame_cnt_q;
  assign stat_runt_cnt_o  = runt_cnt_q;

endmodule

// File: tb/tb_taxi_eth_mac_swap.sv
// tb_taxi_eth_mac_swap: scoreboard bench for the MAC address swap stage.
// Stimulus tasks push the expected output beats into a queue; an independent
// monitor pops and compares on every downstream handshake.
module tb_taxi_eth_mac_swap;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic [7:0] id;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic             s_tlast;
  logic             s_tuser;
  logic [7:0]       s_tid;
  logic [7:0]       m_tdata;
  logic             m_tkeep;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic             m_tlast;
  logic             m_tuser;
  logic [7:0]       m_tid;
  logic             cfg_enable;
  logic [CNT_W-1:0] stat_frame_cnt;
  logic [CNT_W-1:0] stat_runt_cnt;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    exp_frames = 0;
  int    exp_runts = 0;
  bit    rand_ready = 1'b0;
  bit    fixed_ready = 1'b1;

  localparam logic [47:0] MAC_A = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_B = 48'h02_00_00_00_00_02;

  taxi_eth_mac_swap #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata_i   (s_tdata),
    .s_axis_tvalid_i  (s_tvalid),
    .s_axis_tready_o  (s_tready),
    .s_axis_tlast_i   (s_tlast),
    .s_axis_tuser_i   (s_tuser),
    .s_axis_tid_i     (s_tid),
    .m_axis_tdata_o   (m_tdata),
    .m_axis_tkeep_o   (m_tkeep),
    .m_axis_tvalid_o  (m_tvalid),
    .m_axis_tready_i  (m_tready),
    .m_axis_tlast_o   (m_tlast),
    .m_axis_tuser_o   (m_tuser),
    .m_axis_tid_o     (m_tid),
    .cfg_enable_i     (cfg_enable),
    .stat_frame_cnt_o (stat_frame_cnt),
    .stat_runt_cnt_o  (stat_runt_cnt)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready: fixed or random, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : fixed_ready;
  end

  // Monitor: a beat seen valid&ready here completes on the next rising edge.
  beat_t held;
  bit    held_v = 1'b0;
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {m_tdata, m_tlast, m_tuser, m_tid};
    if (!rst && m_tvalid) begin
      check("tkeep", 64'(m_tkeep), 64'(1));
      if (held_v) check("hold_stable", 64'(cur), 64'(held));
      if (m_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(cur), 64'(e));
        end
        held_v = 1'b0;
      end else begin
        held   = cur;
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // Present one beat and wait (bounded) for it to be accepted.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic user,
                           input logic [7:0] id, input bit gaps);
    int budget;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    s_tuser  = user;
    s_tid    = id;
    budget   = 0;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      budget++;
      if (budget > 2000) begin
        total++;
        bad++;
        $display("FAIL s_tready_timeout: got 0 expected 1");
        break;
      end
    end
  endtask

  // Build a frame: dst, src, then payload bytes counting up from id.
  // Expected output goes to the scoreboard before any byte is sent.
  // stop_at >= 0 abandons the frame after that many beats.
  task automatic send_frame(input int len, input logic [47:0] dst, input logic [47:0] src,
                            input logic [7:0] id, input bit user_last, input bit exp_swap,
                            input bit gaps, input int toggle_at, input int stop_at,
                            input bit chk_stall);
    logic [7:0] b [];
    beat_t      e;
    int         idx;
    b = new[len];
    for (int i = 0; i < len; i++) begin
      if (i < 6)       b[i] = dst[8*(5-i) +: 8];
      else if (i < 12) b[i] = src[8*(11-i) +: 8];
      else             b[i] = 8'(i - 12) + id;
    end
    if (len >= 12) begin
      for (int i = 0; i < len; i++) begin
        idx    = (exp_swap && i < 12) ? (i + 6) % 12 : i;
        e.data = b[idx];
        e.last = (i == len - 1);
        e.user = user_last && (i == len - 1);
        e.id   = id;
        exp_q.push_back(e);
      end
      exp_frames++;
    end else begin
      exp_runts++;
    end
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) return;
      if (i == toggle_at) cfg_enable = ~cfg_enable;
      send_beat(b[i], i == len - 1, user_last && (i == len - 1), id, gaps);
      if (chk_stall && i == 11) check("emit_stall_tready", 64'(s_tready), 64'(0));
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has left the DUT.
  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_cnt"}, 64'(stat_frame_cnt), 64'(exp_frames));
    check({tag, "_runt_cnt"}, 64'(stat_runt_cnt), 64'(exp_runts));
  endtask

  initial begin
    int len;
    rst        = 1'b0;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    s_tlast    = 1'b0;
    s_tuser    = 1'b0;
    s_tid      = '0;
    cfg_enable = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tdata", 64'(m_tdata), 64'(0));
    check("rst_m_tlast_tuser_tid", 64'({m_tlast, m_tuser, m_tid}), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check_counters("rst");
    rst = 1'b0;
    #1 check("s_tready_before_edge", 64'(s_tready), 64'(0));
    @(posedge clk);
    #1 check("s_tready_after_edge", 64'(s_tready), 64'(1));

    // basic swap, ready held high
    send_frame(64, MAC_A, MAC_B, 8'h00, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1);
    wait_drain();
    check_counters("basic");

    // exactly 12 bytes with tuser, then a normal frame
    send_frame(12, MAC_A, MAC_B, 8'h12, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0);
    send_frame(64, MAC_B, MAC_A, 8'h13, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0);
    wait_drain();
    check_counters("hdr12");

    // runts: 8 bytes and the 11-byte boundary, then a normal frame
    send_frame(8, MAC_A, MAC_B, 8'h20, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0);
    send_frame(11, MAC_A, MAC_B, 8'h21, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0);
    send_frame(64, MAC_A, MAC_B, 8'h22, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0);
    wait_drain();
    check_counters("runt");

    // enable off, raised at byte 3: this frame unmodified, next one swapped
    cfg_enable = 1'b0;
    send_frame(64, MAC_A, MAC_B, 8'h30, 1'b0, 1'b0, 1'b0, 3, -1, 1'b0);
    send_frame(64, MAC_A, MAC_B, 8'h31, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0);
    wait_drain();
    check_counters("enable");

    // backpressure and input gaps
    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      len = (f % 5 == 0) ? 12 + f : int'($urandom_range(12, 200));
      send_frame(len, MAC_A ^ 48'(f), MAC_B ^ 48'(f * 3), 8'(8'h40 + f),
                 1'($urandom_range(0, 1)), 1'b1, 1'b1, -1, -1, 1'b0);
    end
    send_frame(5, MAC_A, MAC_B, 8'h7f, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    check_counters("bp");

    // reset in the middle of the payload
    send_frame(64, MAC_A, MAC_B, 8'h50, 1'b0, 1'b1, 1'b0, -1, 30, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 64'(m_tvalid), 64'(0));
    exp_q.delete();
    exp_frames = 0;
    exp_runts  = 0;
    check_counters("midrst");
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(64, MAC_B, MAC_A, 8'h51, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0);
    wait_drain();
    check_counters("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taxi_eth_mac_swap.md
# taxi_eth_mac_swap

Single-clock 8-bit AXI4-Stream stage that swaps the Ethernet destination and source MAC addresses of every frame and passes the rest of the frame through unchanged. Sits between the 1G MAC RX FIFO output (`m_axis_rx`) and the MAC TX input (`s_axis_tx`) on the logic clock. Loopback traffic therefore returns to the sender with correct addressing. Drops runt frames that end before the full 12-byte address header.

## Interface
Parameters:
- `CNT_W`, 32: width of statistics counters.

Ports:
- `clk`  in  1: logic clock (125 MHz).
- `rst`  in  1: reset; asynchronous, active-high.
- `s_axis`  taxi_axis_if.snk: DATA_W=8, ID_W=8, USER_W=1. Upstream frames; `tkeep` ignored.
- `m_axis`  taxi_axis_if.src: DATA_W=8, ID_W=8, USER_W=1. Downstream frames; `tkeep` driven 1.
- `cfg_enable`  in  1: 1 = swap addresses, 0 = pass frame unmodified. Sampled on each frame's first input beat.
- `stat_frame_cnt`  out  CNT_W: count of frames completed on `m_axis` (beat with `tlast` handshake); wraps at 2^CNT_W.
- `stat_runt_cnt`  out  CNT_W: count of dropped runt frames; wraps.

## Operation
- States: HDR, EMIT, PASS.
- HDR (reset state):
  - `s_tready`=1.
  - Each accepted beat is written to `hdr[cnt]` with 4-bit `cnt` 0..11.
  - The first beat latches `tid` and `swap = cfg_enable`.
  - `tlast` at `cnt`<11 is a runt: discard the buffer, increment `stat_runt_cnt`, set `cnt`=0, stay in HDR; nothing is emitted.
  - Beat at `cnt`=11 latches `hdr_last = tlast` and `hdr_user = tuser`, then go to EMIT with `ecnt`=0.
- EMIT:
  - `s_tready`=0.
  - The output register loads one byte per load slot, `ecnt` 0..11.
  - Source index is `(ecnt+6) mod 12` if `swap`, else `ecnt`.
  - `tid` is the latched id.
  - `tlast`/`tuser` are asserted only on `ecnt`=11, and only when `hdr_last`; `tuser` = `hdr_user` there, else 0.
  - After loading `ecnt`=11: if `hdr_last`, go to HDR (`cnt`=0); otherwise go to PASS.
- PASS:
  - `s_tready = !m_tvalid || m_tready`.
  - Accepted beats load the output register verbatim (`tdata`, `tlast`, `tuser`, `tid`).
  - Accepting a `tlast` beat returns the block to HDR, `cnt`=0.
- Output register:
  - A load slot is any cycle with `!m_tvalid || m_tready`.
  - `m_tvalid` clears when `m_tready` is high and there is no new load.
- Counter increments are +1 modulo 2^CNT_W. A runt and a frame completion in the same cycle each increment their own counter.
- A `cfg_enable` change mid-frame has no effect until the next frame's first beat.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `m_tuser`=0, `m_tid`=0, `s_tready`=0 while `rst` is high.
  - All counters, `cnt`, `ecnt` = 0; state = HDR.
- `s_tready`=1 from the first clock edge after `rst` deasserts.
- Reset mid-frame:
  - The partial frame is lost and `m_tvalid` drops immediately (asynchronously).
  - The next beat after release is treated as byte 0 of a new header.
- HDR to EMIT: the 12th header beat is accepted at edge N. Output byte 0 is valid after edge N+1.
- With `m_tready` held high, EMIT takes 12 cycles and the first payload byte is accepted in the cycle after the last EMIT load.
- PASS latency is 1 cycle, with full throughput (1 byte/cycle).
- Per-frame overhead is 12 cycles of input stall. This stays within line rate at 125 MHz because preamble+IFG is 20 byte times.
- `m_axis` signals must hold stable while `m_tvalid && !m_tready`.

## Test plan
- **Basic swap:** 64-byte frame, dst 02:00:00:00:00:01, src 02:00:00:00:00:02, payload 0x00..0x33, `m_tready`=1 -> output bytes 0-5 = 02:00:00:00:00:02, bytes 6-11 = 02:00:00:00:00:01, bytes 12-63 identical. `tlast` only on byte 64; `stat_frame_cnt`=1.
- **12-byte frame:** exactly 12 bytes with `tuser`=1 on the last beat -> 12 swapped bytes, `tlast`=`tuser`=1 on the 12th, then return to HDR. A following 64-byte frame is correct.
- **Runt drop:** 8-byte frame, then the basic-swap frame -> no output for the runt, `stat_runt_cnt`=1, `stat_frame_cnt`=1. The second frame is swapped correctly.
- **Backpressure:** 200 frames of random length 12-1518, random `m_tready` (50%) and `s_tvalid` gaps -> byte-exact match to the reference model, `tid` preserved, `stat_frame_cnt`=200.
- **Enable control:** frame with `cfg_enable`=0 -> output identical to input. Toggling `cfg_enable` to 1 at byte 3 of that frame -> still unmodified; the next frame is swapped.
- **Reset mid-PASS:** assert `rst` at byte 30 of a 64-byte frame -> `m_tvalid`=0 at once and counters = 0. After release, a fresh 64-byte frame is swapped correctly.
